// File: rtl/racc_master.sv
// Racc ring initiator: issues one command at a time as an 80-bit request slot and
// retires the matching response, forwarding all foreign slots through one register stage.
module racc_master #(
  parameter logic [3:0]  NODE_ID = 4'h1,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_vld,
  output logic        o_cmd_rdy,
  input  logic        i_cmd_wr,
  input  logic [3:0]  i_cmd_mask,
  input  logic [31:0] i_cmd_addr,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_vld,
  input  logic        i_rsp_rdy,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  input  logic [79:0] i_racc_in,
  output logic [79:0] o_racc_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_seq;
  logic [9:0]  r_timer;
  logic        r_req_wr;
  logic [3:0]  r_req_mask;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_data;
  logic        r_cmd_rdy;
  logic        r_rsp_vld;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic [79:0] r_racc_out;

  logic        w_own;
  logic        w_match;
  logic        w_expire;
  logic        w_accept;
  logic        w_insert;
  logic        w_rsp_load;
  logic [31:0] w_rsp_data_nxt;
  logic        w_rsp_err_nxt;
  logic [79:0] w_slot_next;

  // Any valid slot carrying our ID is ours to retire; only a SEQ hit in WAIT completes.
  assign w_own      = i_racc_in[79] && (i_racc_in[71:68] == NODE_ID);
  assign w_match    = (r_state == S_WAIT) && w_own && (i_racc_in[67:64] == r_seq);
  assign w_expire   = (r_state == S_WAIT) && (r_timer == TMO_LAST);
  assign w_accept   = i_cmd_vld && r_cmd_rdy;
  assign w_insert   = (r_state == S_SEND) && !i_racc_in[79];
  assign w_rsp_load = (r_state == S_WAIT) && (w_next == S_DONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_SEND : S_IDLE;
      S_SEND:  w_next = w_insert ? S_WAIT : S_SEND;
      S_WAIT:  w_next = (w_match || w_expire) ? S_DONE : S_WAIT;
      S_DONE:  w_next = i_rsp_rdy ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_slot_next    = i_racc_in;
    w_rsp_data_nxt = 32'h0000_0000;
    w_rsp_err_nxt  = 1'b1;
    if (w_insert) begin
      w_slot_next = {1'b1, 1'b0, r_req_wr, r_req_mask, 1'b0, NODE_ID, r_seq,
                     r_req_addr, r_req_data};
    end else if (w_own) begin
      w_slot_next = 80'h0;
    end else begin
      w_slot_next = i_racc_in;
    end
    // Our own request coming back with RSP=0 means nobody claimed it.
    if (w_match && i_racc_in[78]) begin
      w_rsp_data_nxt = i_racc_in[31:0];
      w_rsp_err_nxt  = i_racc_in[72];
    end else begin
      w_rsp_data_nxt = 32'h0000_0000;
      w_rsp_err_nxt  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req_wr   <= 1'b0;
      r_req_mask <= 4'h0;
      r_req_addr <= 32'h0000_0000;
      r_req_data <= 32'h0000_0000;
    end else if (w_accept) begin
      r_req_wr   <= i_cmd_wr;
      r_req_mask <= i_cmd_wr ? i_cmd_mask : 4'hF;
      r_req_addr <= i_cmd_addr;
      r_req_data <= i_cmd_data;
    end else begin
      r_req_wr   <= r_req_wr;
      r_req_mask <= r_req_mask;
      r_req_addr <= r_req_addr;
      r_req_data <= r_req_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seq   <= 4'h0;
      r_timer <= 10'd0;
    end else begin
      r_seq   <= ((r_state == S_DONE) && i_rsp_rdy) ? r_seq + 4'h1 : r_seq;
      if (w_insert) begin
        r_timer <= 10'd0;
      end else if (r_state == S_WAIT) begin
        r_timer <= r_timer + 10'd1;
      end else begin
        r_timer <= r_timer;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_racc_out <= 80'h0;
      r_cmd_rdy  <= 1'b0;
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= 32'h0000_0000;
      r_rsp_err  <= 1'b0;
    end else begin
      r_racc_out <= w_slot_next;
      r_cmd_rdy  <= (w_next == S_IDLE);
      r_rsp_vld  <= (w_next == S_DONE);
      r_rsp_data <= w_rsp_load ? w_rsp_data_nxt : r_rsp_data;
      r_rsp_err  <= w_rsp_load ? w_rsp_err_nxt : r_rsp_err;
    end
  end

  assign o_racc_out = r_racc_out;
  assign o_cmd_rdy  = r_cmd_rdy;
  assign o_rsp_vld  = r_rsp_vld;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_racc_master.sv
// Bench for racc_master: a short ring with an sram responder and a foreign-node sink,
// checked against a transaction-level model of expected completions.
module tb_racc_master;

  localparam int TMO      = 16;
  localparam int RING_LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic        cmd_wr = 1'b0;
  logic [3:0]  cmd_mask = 4'h0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [79:0] racc_in = 80'h0;
  logic [79:0] racc_out;

  int errors = 0;
  int checks = 0;

  logic [79:0] ring_q[$];
  logic [31:0] sram_mem[logic [31:0]];
  logic [31:0] exp_mem[logic [31:0]];
  logic        stall = 1'b0;
  logic [79:0] stash = 80'h0;
  logic [79:0] last_out = 80'h0;
  logic [3:0]  mdl_seq = 4'h0;
  logic [31:0] addrs[4];

  always #5 clk = ~clk;

  racc_master #(.NODE_ID(4'h1), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_vld(cmd_vld), .o_cmd_rdy(cmd_rdy), .i_cmd_wr(cmd_wr),
    .i_cmd_mask(cmd_mask), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
    .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .i_racc_in(racc_in), .o_racc_out(racc_out)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the ring: capture DUT output, let the responder/sink act, feed the next slot back.
  task automatic tick();
    logic [79:0] s;
    logic [31:0] key;
    logic [31:0] old;
    @(posedge clk);
    #1;
    last_out = racc_out;
    s = last_out;
    if (s[79]) begin
      if (s[71:68] != 4'h1) begin
        s = 80'h0;
      end else if (!s[78] && (s[63:48] == 16'hFFFF)) begin
        if (stall) begin
          stash = s;
          s = 80'h0;
        end else begin
          key = {s[63:34], 2'b00};
          old = sram_mem.exists(key) ? sram_mem[key] : 32'h0;
          if (s[77]) begin
            for (int b = 0; b < 4; b++) if (s[73+b]) old[8*b +: 8] = s[8*b +: 8];
            sram_mem[key] = old;
          end else begin
            s[31:0] = old;
          end
          s[78] = 1'b1;
        end
      end
    end
    ring_q.push_back(s);
    racc_in = ring_q.pop_front();
  endtask

  task automatic do_txn(input logic wr, input logic [3:0] mask, input logic [31:0] addr,
                        input logic [31:0] data, input int n_foreign, input int hold,
                        input logic use_stall);
    logic [3:0]  eff_mask;
    logic [31:0] key;
    logic [31:0] bm;
    logic [31:0] old;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          n;
    logic [79:0] f;
    logic [79:0] late;
    eff_mask = wr ? mask : 4'hF;
    key = {addr[31:2], 2'b00};
    if (addr[31:16] != 16'hFFFF) begin
      exp_err = 1'b1; exp_data = 32'h0; exp_lat = RING_LAT + 1;
    end else if (use_stall) begin
      exp_err = 1'b1; exp_data = 32'h0; exp_lat = TMO;
    end else if (wr) begin
      old = exp_mem.exists(key) ? exp_mem[key] : 32'h0;
      bm = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
      exp_mem[key] = (old & ~bm) | (data & bm);
      exp_err = 1'b0; exp_data = data; exp_lat = RING_LAT + 1;
    end else begin
      exp_err = 1'b0; exp_data = exp_mem.exists(key) ? exp_mem[key] : 32'h0;
      exp_lat = RING_LAT + 1;
    end
    stall = use_stall;
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin tick(); n++; end
    chk("cmd_rdy_idle", 80'(cmd_rdy), 80'(1'b1));
    cmd_vld = 1'b1; cmd_wr = wr; cmd_mask = mask; cmd_addr = addr; cmd_data = data;
    tick();
    cmd_vld = 1'b0;
    chk("cmd_rdy_busy", 80'(cmd_rdy), 80'(1'b0));
    for (int k = 0; k < n_foreign; k++) begin
      f[31:0] = $urandom; f[63:32] = $urandom; f[79:64] = 16'($urandom);
      f[79] = 1'b1; f[71:68] = 4'h2;
      racc_in = f;
      tick();
      chk("fwd_foreign", last_out, f);
    end
    tick();
    chk("req_slot", last_out, {1'b1, 1'b0, wr, eff_mask, 1'b0, 4'h1, mdl_seq, addr, data});
    n = 0;
    while (rsp_vld !== 1'b1 && n < TMO + 10) begin tick(); n++; end
    chk("rsp_latency", 80'(n), 80'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("rsp_vld_hold", 80'(rsp_vld), 80'(1'b1));
    end
    chk("rsp_data", 80'(rsp_data), 80'(exp_data));
    chk("rsp_err", 80'(rsp_err), 80'(exp_err));
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    chk("rsp_vld_clr", 80'(rsp_vld), 80'(1'b0));
    mdl_seq = mdl_seq + 4'h1;
    if (use_stall) begin
      late = stash;
      late[78] = 1'b1;
      late[31:0] = $urandom;
      stall = 1'b0;
      racc_in = late;
      tick();
      chk("late_dropped", last_out, 80'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < RING_LAT; i++) ring_q.push_back(80'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_racc_out", racc_out, 80'h0);
    chk("rst_cmd_rdy", 80'(cmd_rdy), 80'(1'b0));
    chk("rst_rsp_vld", 80'(rsp_vld), 80'(1'b0));
    chk("rst_rsp_data", 80'(rsp_data), 80'(32'h0));
    chk("rst_rsp_err", 80'(rsp_err), 80'(1'b0));
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", 80'(cmd_rdy), 80'(1'b1));

    // sram write then read back
    do_txn(1'b1, 4'hF, 32'hFFFF_0010, 32'hDEAD_BEEF, 0, 0, 1'b0);
    do_txn(1'b0, 4'h0, 32'hFFFF_0010, 32'h0, 0, 0, 1'b0);
    // unclaimed read
    do_txn(1'b0, 4'h3, 32'h0000_1000, 32'h1234_5678, 0, 0, 1'b0);
    // partial-mask writes to a few random sram words
    for (int i = 0; i < 4; i++) begin
      addrs[i] = 32'hFFFF_0000 | ($urandom & 32'h0000_3FFC);
      do_txn(1'b1, 4'hF, addrs[i], $urandom, 0, 0, 1'b0);
      do_txn(1'b1, 4'($urandom_range(1, 14)), addrs[i], $urandom, 0, 1, 1'b0);
    end
    // ring occupied by foreign slots before insertion
    do_txn(1'b1, 4'($urandom), addrs[0], $urandom, 5, 0, 1'b0);
    // responder stalled: timeout, then the late response is dropped
    do_txn(1'b0, 4'hF, addrs[1], 32'h0, 0, 0, 1'b1);
    // back-to-back reads with slow consumer; SEQ wraps
    for (int i = 0; i < 17; i++) begin
      do_txn(1'b0, 4'($urandom), addrs[i % 4], $urandom, 0, 3, 1'b0);
    end

    // reset in WAIT
    do_txn(1'b1, 4'hF, 32'hFFFF_0020, 32'hCAFE_F00D, 0, 0, 1'b0);
    stall = 1'b1;
    cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_mask = 4'hF; cmd_addr = 32'hFFFF_0020;
    tick();
    cmd_vld = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("rst_wait_out", racc_out, 80'h0);
    chk("rst_wait_vld", 80'(rsp_vld), 80'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    ring_q.delete();
    for (int i = 0; i < RING_LAT; i++) ring_q.push_back(80'h0);
    racc_in = 80'h0;
    mdl_seq = 4'h0;
    tick();
    chk("rel_racc_out", racc_out, 80'h0);
    chk("rel_rsp_vld", 80'(rsp_vld), 80'(1'b0));
    chk("rel_cmd_rdy", 80'(cmd_rdy), 80'(1'b1));
    do_txn(1'b0, 4'h0, 32'hFFFF_0020, 32'h0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
